// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV64I control path: FSM states, opcodes,
// and the select encodings driven into the datapath and the immediate generator.
package rv_ctrl_pkg;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;

  localparam logic [2:0] IMM_I  = 3'd0;
  localparam logic [2:0] IMM_S  = 3'd1;
  localparam logic [2:0] IMM_SB = 3'd2;
  localparam logic [2:0] IMM_U  = 3'd3;
  localparam logic [2:0] IMM_UJ = 3'd4;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] SRCA_RS1  = 2'd0;
  localparam logic [1:0] SRCA_PC   = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_CMP   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  function automatic logic opc_legal(input logic [6:0] op);
    case (op)
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP_IMM32, OPC_OP, OPC_OP32,
      OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: opc_legal = 1'b1;
      default:                                           opc_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] imm_sel_of(input logic [6:0] op);
    case (op)
      OPC_STORE:          imm_sel_of = IMM_S;
      OPC_BRANCH:         imm_sel_of = IMM_SB;
      OPC_LUI, OPC_AUIPC: imm_sel_of = IMM_U;
      OPC_JAL:            imm_sel_of = IMM_UJ;
      default:            imm_sel_of = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_branch.sv
// Branch condition evaluation: funct3 plus ALU compare flags to taken.
module rv_branch_cond (
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       lt_i,
  input  logic       ltu_i,
  output logic       taken_o
);

  always_comb begin
    case (funct3_i)
      3'b000:  taken_o = zero_i;
      3'b001:  taken_o = ~zero_i;
      3'b100:  taken_o = lt_i;
      3'b101:  taken_o = ~lt_i;
      3'b110:  taken_o = ltu_i;
      3'b111:  taken_o = ~ltu_i;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV64I datapath (shared memory port).
// Optional RV_CTRL_INSTRET_CNT_EN adds a 64-bit retired-instruction counter.
module rv_multicycle_ctrl import rv_ctrl_pkg::*; #(
  parameter logic [2:0] RESET_STATE = S_FETCH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        alu_ltu,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_ifetch,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [2:0]  imm_sel,
  output logic [1:0]  alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        alu_word,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
`ifdef RV_CTRL_INSTRET_CNT_EN
  output logic [63:0] instret,
`endif
  output logic        illegal
);

  logic [2:0] state_q, state_d;
  logic       taken;

  logic is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic is_op, is_op32, is_opimm, is_opimm32;
  assign is_load    = (opcode == OPC_LOAD);
  assign is_store   = (opcode == OPC_STORE);
  assign is_branch  = (opcode == OPC_BRANCH);
  assign is_jal     = (opcode == OPC_JAL);
  assign is_jalr    = (opcode == OPC_JALR);
  assign is_lui     = (opcode == OPC_LUI);
  assign is_auipc   = (opcode == OPC_AUIPC);
  assign is_op      = (opcode == OPC_OP);
  assign is_op32    = (opcode == OPC_OP32);
  assign is_opimm   = (opcode == OPC_OP_IMM);
  assign is_opimm32 = (opcode == OPC_OP_IMM32);

  // ALU operand/op selects for the decoded class; held from EXEC through WB
  logic [1:0] dp_src_a, dp_op;
  logic       dp_src_b;
  assign dp_src_a = is_lui ? SRCA_ZERO : (is_auipc ? SRCA_PC : SRCA_RS1);
  assign dp_src_b = ~(is_op | is_op32 | is_branch);
  assign dp_op    = (is_op | is_op32 | is_opimm | is_opimm32) ? ALU_FUNCT :
                    (is_branch ? ALU_CMP : ALU_ADD);

  rv_branch_cond u_branch_cond (
    .funct3_i (funct3),
    .zero_i   (alu_zero),
    .lt_i     (alu_lt),
    .ltu_i    (alu_ltu),
    .taken_o  (taken)
  );

  // Outputs are forced low while reset is held so mem_req drops without a clock edge
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_ifetch = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS4;
    imm_sel    = IMM_I;
    alu_src_a  = SRCA_RS1;
    alu_src_b  = 1'b0;
    alu_op     = ALU_ADD;
    alu_word   = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = WB_ALU;
    illegal    = 1'b0;
    if (!reset) begin
      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
        imm_sel   = imm_sel_of(opcode);
        alu_src_a = dp_src_a;
        alu_src_b = dp_src_b;
        alu_op    = dp_op;
        alu_word  = is_op32 | is_opimm32;
      end
      case (state_q)
        S_FETCH: begin
          mem_req    = 1'b1;
          mem_ifetch = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          imm_sel = imm_sel_of(opcode);
          state_d = opc_legal(opcode) ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          if (is_branch) begin
            pc_write = taken;
            pc_src   = taken ? PC_IMM : PC_PLUS4;
            state_d  = S_FETCH;
          end else if (is_jal || is_jalr) begin
            pc_write = 1'b1;
            pc_src   = is_jal ? PC_IMM : PC_ALU;
            state_d  = S_WB;
          end else if (is_load || is_store) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = is_store;
          if (mem_ready) state_d = is_load ? S_WB : S_FETCH;
        end
        S_WB: begin
          reg_write = 1'b1;
          wb_sel    = is_load ? WB_MEM : ((is_jal || is_jalr) ? WB_PC4 : WB_ALU);
          state_d   = S_FETCH;
        end
        S_TRAP:  illegal = 1'b1;
        default: state_d = RESET_STATE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

`ifdef RV_CTRL_INSTRET_CNT_EN
  logic [63:0] instret_q, instret_d;
  logic        retire;
  assign retire    = (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) &&
                     (state_d == S_FETCH);
  assign instret_d = retire ? instret_q + 64'd1 : instret_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) instret_q <= '0;
    else       instret_q <= instret_d;
  end

  assign instret = instret_q;
`endif

endmodule
